// File: rtl/im_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit instruction-memory writes,
// verifies a trailing XOR checksum and keeps the CPU stalled until a clean load finishes.
module im_loader #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 254,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  len_in,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_waddr,
   output logic [31:0]       im_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_hold,
   output logic [2:0]        o_dbg_state
);

   // Handshake: a byte moves on a rising edge where byte_valid && byte_ready; the producer
   // must hold byte_data stable while byte_valid is high and byte_ready is low.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_len;
   logic [CNT_W-1:0]  r_word_idx;
   logic [1:0]        r_byte_cnt;
   logic [7:0]        r_chk;
   logic [23:0]       r_asm;

   logic              w_xfer;
   logic              w_len_bad;
   logic              w_last_word;
   logic [ADDR_W-1:0] w_waddr;

   assign w_xfer      = byte_valid && byte_ready;
   assign w_len_bad   = (len_in > CNT_W'(MAX_WORDS));
   assign w_last_word = (r_word_idx == (r_len - CNT_W'(1)));
   assign w_waddr     = ADDR_W'({r_word_idx, 2'b00});
   assign o_dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_word_idx <= '0;
         r_byte_cnt <= '0;
         r_chk      <= '0;
         r_asm      <= '0;
         byte_ready <= 1'b0;
         im_we      <= 1'b0;
         im_waddr   <= '0;
         im_wdata   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cpu_hold   <= 1'b1;
      end else begin
         im_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_len      <= len_in;
                  r_word_idx <= '0;
                  r_byte_cnt <= '0;
                  r_chk      <= '0;
                  cpu_hold   <= 1'b1;
                  if (w_len_bad) begin
                     r_state    <= S_DONE;
                     done       <= 1'b1;
                     err        <= 1'b1;
                     busy       <= 1'b0;
                     byte_ready <= 1'b0;
                  end else begin
                     r_state    <= (len_in == '0) ? S_CHECK : S_RECV;
                     done       <= 1'b0;
                     err        <= 1'b0;
                     busy       <= 1'b1;
                     byte_ready <= 1'b1;
                  end
               end
            end

            S_RECV: begin
               if (w_xfer) begin
                  r_chk      <= r_chk ^ byte_data;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  case (r_byte_cnt)
                     2'd0: r_asm[7:0]   <= byte_data;
                     2'd1: r_asm[15:8]  <= byte_data;
                     2'd2: r_asm[23:16] <= byte_data;
                     default: begin
                        // Fourth byte completes the word; the strobe lands in WRITE.
                        im_we      <= 1'b1;
                        im_waddr   <= w_waddr;
                        im_wdata   <= {byte_data, r_asm};
                        byte_ready <= 1'b0;
                        r_state    <= S_WRITE;
                     end
                  endcase
               end
            end

            S_WRITE: begin
               byte_ready <= 1'b1;
               if (w_last_word) begin
                  r_state <= S_CHECK;
               end else begin
                  r_word_idx <= r_word_idx + CNT_W'(1);
                  r_state    <= S_RECV;
               end
            end

            S_CHECK: begin
               if (w_xfer) begin
                  r_state    <= S_DONE;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  byte_ready <= 1'b0;
                  err        <= (byte_data != r_chk);
                  cpu_hold   <= (byte_data != r_chk);
               end
            end

            default: begin
               r_state    <= S_IDLE;
               byte_ready <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: driver tasks feed byte streams, a scoreboard queue holds expected
// {addr,data} writes and a negedge monitor pops and compares them as the DUT strobes im_we.
module tb_im_loader;

   localparam int ADDR_W    = 10;
   localparam int MAX_WORDS = 254;
   localparam int CNT_W     = 8;

   logic              clk;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  len_in;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_waddr;
   logic [31:0]       im_wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic              cpu_hold;
   logic [2:0]        dbg_state;

   int total = 0;
   int bad   = 0;

   logic [ADDR_W+31:0] exp_q[$];
   logic [7:0]         stim_q[$];
   logic               drv_last;
   logic               pend_we;
   int                 acc_bytes;

   im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .len_in      (len_in),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_ready  (byte_ready),
      .im_we       (im_we),
      .im_waddr    (im_waddr),
      .im_wdata    (im_wdata),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .cpu_hold    (cpu_hold),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial pend_we = 1'b0;
   always @(negedge clk) begin
      logic [ADDR_W+31:0] exp_w;
      if (pend_we || im_we === 1'b1)
         check("write_latency", {63'd0, im_we}, {63'd0, pend_we});
      if (im_we === 1'b1) begin
         check("ready_in_write", {63'd0, byte_ready}, 64'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr %0h data %0h with empty queue", im_waddr, im_wdata);
         end else begin
            exp_w = exp_q.pop_front();
            check("write_addr_data", {22'd0, im_waddr, im_wdata}, {22'd0, exp_w});
         end
      end
      if (byte_valid && byte_ready) acc_bytes++;
      pend_we = byte_valid && byte_ready && drv_last && !rst;
   end

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic do_start(input logic [CNT_W-1:0] len);
      start  = 1'b1;
      len_in = len;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
      int n;
      int k;
      byte_data  = b;
      byte_valid = 1'b1;
      drv_last   = last;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (byte_ready) break;
      end
      if (n == 200) begin
         total++;
         bad++;
         $display("FAIL byte_timeout: byte %0h never accepted", b);
      end
      @(posedge clk); #1;
      drv_last = 1'b0;
      if (gaps) begin
         k = $urandom_range(0, 2);
         if (k > 0) begin
            byte_valid = 1'b0;
            repeat (k) @(posedge clk);
            #1;
         end
      end
   endtask

   // Reference model: words are little-endian groups of stim_q, checksum is XOR of all bytes.
   task automatic run_load(input int len, input bit gaps, input logic [7:0] cs, input bit poke_start);
      logic [7:0]  x;
      logic [31:0] word;
      bit          exp_err;
      x = 8'd0;
      foreach (stim_q[i]) x = x ^ stim_q[i];
      exp_err   = (cs != x);
      acc_bytes = 0;
      do_start(CNT_W'(len));
      check("start_done_clr", {62'd0, done, err}, 64'd0);
      check("start_busy_hold", {62'd0, busy, cpu_hold}, 64'd3);
      for (int i = 0; i < 4 * len; i++) begin
         if (poke_start && i == 1) begin
            start  = 1'b1;
            len_in = 8'd255;
         end
         if (i % 4 == 3) begin
            word = 32'(stim_q[i-3]) + (32'(stim_q[i-2]) << 8) +
                   (32'(stim_q[i-1]) << 16) + (32'(stim_q[i]) << 24);
            exp_q.push_back({ADDR_W'((i / 4) * 4), word});
         end
         send_byte(stim_q[i], (i % 4 == 3), gaps);
         start = 1'b0;
      end
      send_byte(cs, 1'b0, gaps);
      byte_valid = 1'b0;
      @(negedge clk);
      check("end_done_err", {62'd0, done, err}, {62'd0, 1'b1, exp_err});
      check("end_hold_busy", {62'd0, cpu_hold, busy}, {62'd0, exp_err, 1'b0});
      check("end_ready", {63'd0, byte_ready}, 64'd0);
      check("bytes_consumed", 64'(acc_bytes), 64'(4 * len + 1));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic rand_stim(input int len);
      stim_q.delete();
      for (int i = 0; i < 4 * len; i++) stim_q.push_back(8'($urandom_range(0, 255)));
   endtask

   function automatic logic [7:0] xor_of_stim();
      logic [7:0] x;
      x = 8'd0;
      foreach (stim_q[i]) x = x ^ stim_q[i];
      return x;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      len_in     = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      drv_last   = 1'b0;
      acc_bytes  = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_flags", {60'd0, byte_ready, im_we, busy, done}, 64'd0);
      check("rst_err_hold", {62'd0, err, cpu_hold}, 64'd1);
      check("rst_addr_data", {22'd0, im_waddr, im_wdata}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Normal 2-word load, continuous valid, then bad checksum with gaps.
      stim_q = '{8'h05, 8'h00, 8'h08, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
      run_load(2, 1'b0, 8'h69, 1'b0);
      stim_q = '{8'h05, 8'h00, 8'h08, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
      run_load(2, 1'b1, 8'h68, 1'b0);
      stim_q = '{8'h05, 8'h00, 8'h08, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
      run_load(2, 1'b1, 8'h69, 1'b0);

      // Restart from DONE after a passing load.
      stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_load(1, 1'b0, 8'h00, 1'b0);

      // Zero-length load.
      stim_q.delete();
      run_load(0, 1'b0, 8'h00, 1'b0);

      // Illegal length: immediate error, ready never rises.
      acc_bytes = 0;
      do_start(8'd255);
      check("bad_len_done_err", {62'd0, done, err}, 64'd3);
      check("bad_len_hold_busy", {62'd0, cpu_hold, busy}, 64'd2);
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bad_len_ready", {63'd0, byte_ready}, 64'd0);
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
      check("bad_len_no_bytes", 64'(acc_bytes), 64'd0);

      // Reset after two bytes of the second word: only word 0 is written.
      rand_stim(2);
      do_start(8'd2);
      for (int i = 0; i < 6; i++) begin
         if (i == 3)
            exp_q.push_back({ADDR_W'(0), stim_q[3], stim_q[2], stim_q[1], stim_q[0]});
         send_byte(stim_q[i], (i == 3), 1'b0);
      end
      rst        = 1'b1;
      byte_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy_done", {62'd0, busy, done}, 64'd0);
      check("abort_hold_ready", {62'd0, cpu_hold, byte_ready}, 64'd2);
      check("abort_queue", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rand_stim(1);
      run_load(1, 1'b0, xor_of_stim(), 1'b0);

      // Randomized loads: length, gaps, checksum corruption, start poked while busy.
      for (int t = 0; t < 10; t++) begin
         int  len;
         bit  corrupt;
         logic [7:0] cs;
         len     = $urandom_range(1, 6);
         corrupt = ($urandom_range(0, 3) == 0);
         rand_stim(len);
         cs = xor_of_stim();
         if (corrupt) cs = cs ^ (8'd1 << $urandom_range(0, 7));
         run_load(len, bit'($urandom_range(0, 1)), cs, (t % 3 == 0));
      end

      // Longest legal load reaches the top word address.
      rand_stim(MAX_WORDS);
      run_load(MAX_WORDS, 1'b0, xor_of_stim(), 1'b0);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
